// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access controller.
//   - funct3-style access size codes (SZ_*)
//   - controller FSM state encoding
//   - response owner encoding (which requester port a response belongs to)
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RSP     = 2'd2
    } state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for a 32-bit data RAM.
//   size      in  3   access size code (SZ_*)
//   is_store  in  1   1 = store; masks are forced to 0 for loads
//   byte_off  in  2   addr[1:0]
//   wdata     in  32  LSB-justified store data
//   rdata_raw in  32  raw RAM word
//   wmask     out 4   byte write enables (0 for loads)
//   wdata_rep out 32  store data replicated across lanes
//   rdata_ext out 32  load data shifted down and sign/zero extended
//   err       out 1   misaligned access, illegal size, or unsigned-size store
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic        is_store,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic [31:0] shifted;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign shifted = rdata_raw >> {byte_off, 3'b000};

    always_comb begin
        wmask     = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        err       = 1'b0;
        case (size)
            SZ_B: begin
                wmask     = 4'b0001 << byte_off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wmask     = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
                err       = byte_off[0];
            end
            SZ_W: begin
                wmask     = 4'b1111;
                rdata_ext = shifted;
                err       = |byte_off;
            end
            SZ_BU: begin
                rdata_ext = {24'h0, shifted[7:0]};
                err       = is_store;  // no unsigned store sizes
            end
            SZ_HU: begin
                rdata_ext = {16'h0, shifted[15:0]};
                err       = byte_off[0] | is_store;
            end
            default: err = 1'b1;
        endcase
        if (!is_store) wmask = 4'b0000;
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrates one synchronous-read data RAM between the core
// LSU (port C) and a DMA/debug master (port D). One request in flight at a time;
// each request gets exactly one response on the port that issued it.
//   clk, rst_n              clock, async active-low reset
//   c_req_* / d_req_*       request channel (valid/ready, we, addr, wdata, size)
//   c_rsp_* / d_rsp_*       response channel (valid/ready, rdata, err)
//   mem_en/wmask/addr/wdata RAM strobe, byte enables (0 = read), word index, data
//   mem_rdata               RAM read word, valid the cycle after a read strobe
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_DEPTH  = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         c_req_valid,
    output logic                         c_req_ready,
    input  logic                         c_req_we,
    input  logic [31:0]                  c_req_addr,
    input  logic [31:0]                  c_req_wdata,
    input  logic [2:0]                   c_req_size,
    output logic                         c_rsp_valid,
    input  logic                         c_rsp_ready,
    output logic [31:0]                  c_rsp_rdata,
    output logic                         c_rsp_err,
    input  logic                         d_req_valid,
    output logic                         d_req_ready,
    input  logic                         d_req_we,
    input  logic [31:0]                  d_req_addr,
    input  logic [31:0]                  d_req_wdata,
    input  logic [2:0]                   d_req_size,
    output logic                         d_rsp_valid,
    input  logic                         d_rsp_ready,
    output logic [31:0]                  d_rsp_rdata,
    output logic                         d_rsp_err,
    output logic                         mem_en,
    output logic [3:0]                   mem_wmask,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;

    logic        idle, starved, grant_d, accept, acc_err, range_err, owner_rsp_ready;
    logic        sel_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [2:0]  al_size;
    logic [1:0]  al_off;
    logic        al_store, al_err;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata, al_rdata;
    logic        rsp_vld;

    assign idle    = (state_q == ST_IDLE);
    assign starved = (starve_q == SW'(STARVE_MAX));
    // D wins only when C has nothing to send or D has waited long enough.
    assign grant_d = d_req_valid & (~c_req_valid | starved);

    assign sel_valid = grant_d ? d_req_valid : c_req_valid;
    assign req_we    = grant_d ? d_req_we    : c_req_we;
    assign req_addr  = grant_d ? d_req_addr  : c_req_addr;
    assign req_wdata = grant_d ? d_req_wdata : c_req_wdata;
    assign req_size  = grant_d ? d_req_size  : c_req_size;

    // Ready and strobes are gated by rst_n so nothing leaks out while reset is held.
    assign c_req_ready = rst_n & idle & ~grant_d;
    assign d_req_ready = rst_n & idle & grant_d;
    assign accept      = rst_n & idle & sel_valid;

    assign range_err = (req_addr >= 32'(4 * MEM_DEPTH));

    // One aligner serves both phases: in IDLE it decodes the incoming request,
    // in RD_WAIT it extends the returning word using the latched size/offset.
    assign al_size  = idle ? req_size       : size_q;
    assign al_off   = idle ? req_addr[1:0]  : off_q;
    assign al_store = idle & req_we;

    dmem_lane_align u_align (
        .size      (al_size),
        .is_store  (al_store),
        .byte_off  (al_off),
        .wdata     (req_wdata),
        .rdata_raw (mem_rdata),
        .wmask     (al_wmask),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .err       (al_err)
    );

    assign acc_err   = al_err | range_err;
    assign mem_en    = accept & ~acc_err;
    assign mem_wmask = mem_en ? al_wmask : 4'b0000;
    assign mem_addr  = req_addr[AW+1:2];
    assign mem_wdata = al_wdata;

    assign rsp_vld     = (state_q == ST_RSP);
    assign c_rsp_valid = rsp_vld & (owner_q == OWN_C);
    assign d_rsp_valid = rsp_vld & (owner_q == OWN_D);
    assign c_rsp_rdata = c_rsp_valid ? rsp_rdata_q : 32'h0;
    assign d_rsp_rdata = d_rsp_valid ? rsp_rdata_q : 32'h0;
    assign c_rsp_err   = c_rsp_valid & rsp_err_q;
    assign d_rsp_err   = d_rsp_valid & rsp_err_q;

    assign owner_rsp_ready = (owner_q == OWN_D) ? d_rsp_ready : c_rsp_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        size_d      = size_q;
        off_d       = off_q;
        case (state_q)
            ST_IDLE: begin
                // D waiting while C is served counts toward its forced win.
                if (d_req_valid && !grant_d && !starved) starve_d = starve_q + SW'(1);
                if (accept) begin
                    owner_d     = grant_d ? OWN_D : OWN_C;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = acc_err;
                    size_d      = req_size;
                    off_d       = req_addr[1:0];
                    if (grant_d) starve_d = '0;
                    state_d = (acc_err || req_we) ? ST_RSP : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                rsp_rdata_d = al_rdata;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                // Returning to IDLE (not accepting here) gives the dead cycle.
                if (owner_rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_C;
            starve_q    <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            size_q      <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            size_q      <= size_d;
            off_q       <= off_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int MEM_DEPTH  = 32;
    localparam int STARVE_MAX = 4;
    localparam int AW         = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata;
    logic [2:0]  c_req_size;
    logic d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [2:0]  d_req_size;
    logic          mem_en;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_DEPTH(MEM_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
        .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_req_size(c_req_size),
        .c_rsp_valid(c_rsp_valid), .c_rsp_ready(c_rsp_ready), .c_rsp_rdata(c_rsp_rdata),
        .c_rsp_err(c_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_err(d_rsp_err),
        .mem_en(mem_en), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous-read RAM the controller drives.
    logic [31:0] ram [MEM_DEPTH] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wmask == 4'b0000) mem_rdata <= ram[mem_addr];
            else for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    int tot = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit port; logic [31:0] rdata; bit err; } exp_t;
    exp_t expq[$];
    logic [7:0] mmem [4*MEM_DEPTH] = '{default: 8'h0};

    // Byte-addressed view: an access covers bytes [addr, addr+nb).
    task automatic model_accept(input bit port, input bit we, input logic [31:0] addr,
                                input logic [2:0] sz, input logic [31:0] wd);
        int nb = 1;
        int off;
        bit uns = 0;
        bit err = 0;
        longint unsigned v;
        logic [3:0] m;
        exp_t e;
        case (sz)
            3'b000: nb = 1;
            3'b001: nb = 2;
            3'b010: nb = 4;
            3'b100: begin nb = 1; uns = 1; end
            3'b101: begin nb = 2; uns = 1; end
            default: err = 1;
        endcase
        off = int'(addr[1:0]);
        if (off % nb != 0) err = 1;
        if (addr >= 32'(4 * MEM_DEPTH)) err = 1;
        if (we && uns) err = 1;
        e.port = port; e.err = err; e.rdata = 32'h0;
        if (err) chk("err_no_mem_en", {31'h0, mem_en}, 32'h0);
        else begin
            chk("mem_en", {31'h0, mem_en}, 32'h1);
            chk("mem_addr", {27'h0, mem_addr}, addr >> 2);
            m = 4'b0000;
            for (int i = 0; i < nb; i++) m[off+i] = 1'b1;
            chk("mem_wmask", {28'h0, mem_wmask}, we ? {28'h0, m} : 32'h0);
            if (we) begin
                for (int i = 0; i < nb; i++) begin
                    chk("mem_wdata_lane", {24'h0, mem_wdata[8*(off+i) +: 8]}, {24'h0, wd[8*i +: 8]});
                    mmem[addr+i] = wd[8*i +: 8];
                end
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v | (64'(mmem[addr+i]) << (8*i));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
                e.rdata = v[31:0];
            end
        end
        expq.push_back(e);
    endtask

    // Compare process: responses against the model every cycle they are valid,
    // plus accept-cycle RAM strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_en_only_on_accept",
                {31'h0, mem_en & ~((c_req_valid & c_req_ready) | (d_req_valid & d_req_ready))}, 32'h0);
            if (c_rsp_valid || d_rsp_valid) begin
                chk("rsp_one_port", {31'h0, c_rsp_valid & d_rsp_valid}, 32'h0);
                chk("rsp_pending", {31'h0, expq.size() != 0}, 32'h1);
                if (expq.size() != 0) begin
                    chk("rsp_port", {31'h0, d_rsp_valid}, {31'h0, expq[0].port});
                    chk("rsp_rdata", d_rsp_valid ? d_rsp_rdata : c_rsp_rdata, expq[0].rdata);
                    chk("rsp_err", {31'h0, d_rsp_valid ? d_rsp_err : c_rsp_err}, {31'h0, expq[0].err});
                    if (d_rsp_valid ? d_rsp_ready : c_rsp_ready) void'(expq.pop_front());
                end
            end
            if (c_req_valid && c_req_ready)
                model_accept(1'b0, c_req_we, c_req_addr, c_req_size, c_req_wdata);
            if (d_req_valid && d_req_ready)
                model_accept(1'b1, d_req_we, d_req_addr, d_req_size, d_req_wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                          input logic [2:0] sz, input logic [31:0] wd, input int exp_lat,
                          input string name, output logic [31:0] rd, output logic er);
        int n = 0;
        bit got = 0;
        @(posedge clk); #1;
        if (port) begin
            d_req_valid = 1; d_req_we = we; d_req_addr = addr; d_req_size = sz; d_req_wdata = wd;
        end else begin
            c_req_valid = 1; c_req_we = we; c_req_addr = addr; c_req_size = sz; c_req_wdata = wd;
        end
        while (!got && n < 20) begin
            @(negedge clk); n++;
            got = port ? d_req_ready : c_req_ready;
        end
        chk({name, "_accepted"}, {31'h0, got}, 32'h1);
        @(posedge clk); #1;
        c_req_valid = 0; d_req_valid = 0;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            got = port ? d_rsp_valid : c_rsp_valid;
        end
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        rd = port ? d_rsp_rdata : c_rsp_rdata;
        er = port ? d_rsp_err : c_rsp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int n;
        int g;
        bit seq [10];

        c_req_we = 0; c_req_addr = 0; c_req_wdata = 0; c_req_size = 0; c_rsp_ready = 1;
        d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_size = 0; d_rsp_ready = 1;
        c_req_valid = 1; d_req_valid = 1;
        repeat (2) @(negedge clk);
        chk("rst_c_req_ready", {31'h0, c_req_ready}, 0);
        chk("rst_d_req_ready", {31'h0, d_req_ready}, 0);
        chk("rst_rsp_valid", {30'h0, c_rsp_valid, d_rsp_valid}, 0);
        chk("rst_rsp_err", {30'h0, c_rsp_err, d_rsp_err}, 0);
        chk("rst_mem", {27'h0, mem_en, mem_wmask}, 0);
        c_req_valid = 0; d_req_valid = 0;
        @(posedge clk); #1 rst_n = 1;

        do_req(0, 1, 32'h10, SZ_W, 32'hDEADBEEF, 1, "sw", rd, er);
        chk("sw_rdata", rd, 32'h0);
        chk("ram_word4", ram[4], 32'hDEADBEEF);
        do_req(0, 0, 32'h11, SZ_BU, 0, 2, "lbu", rd, er);
        chk("lbu_rdata", rd, 32'h000000BE);

        do_req(0, 1, 32'h10, SZ_W, 32'h80FF0000, 1, "sw2", rd, er);
        do_req(0, 0, 32'h13, SZ_B, 0, 2, "lb", rd, er);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        do_req(0, 0, 32'h12, SZ_HU, 0, 2, "lhu", rd, er);
        chk("lhu_rdata", rd, 32'h000080FF);
        do_req(0, 0, 32'h12, SZ_H, 0, 2, "lh", rd, er);
        chk("lh_rdata", rd, 32'hFFFF80FF);

        do_req(0, 1, 32'h13, SZ_H, 32'h1234, 1, "sh_mis", rd, er);
        chk("sh_mis_err", {31'h0, er}, 1);
        chk("sh_mis_ram", ram[4], 32'h80FF0000);
        do_req(0, 0, 32'h80, SZ_W, 0, 1, "lw_oor", rd, er);
        chk("lw_oor_err", {31'h0, er}, 1);
        do_req(0, 0, 32'h00, 3'b011, 0, 1, "l_badsz", rd, er);
        chk("l_badsz_err", {31'h0, er}, 1);
        do_req(0, 1, 32'h04, SZ_BU, 32'h55, 1, "sbu", rd, er);
        chk("sbu_err", {31'h0, er}, 1);

        do_req(0, 1, 32'h7F, SZ_B, 32'h000000A5, 1, "sb_top", rd, er);
        chk("sb_top_err", {31'h0, er}, 0);
        do_req(0, 0, 32'h7C, SZ_W, 0, 2, "lw_top", rd, er);
        chk("lw_top_rdata", rd, 32'hA5000000);

        do_req(1, 1, 32'h20, SZ_W, 32'hCAFEF00D, 1, "d_sw", rd, er);
        do_req(1, 0, 32'h22, SZ_H, 0, 2, "d_lh", rd, er);
        chk("d_lh_rdata", rd, 32'hFFFFCAFE);

        // response back-pressure
        @(posedge clk); #1;
        c_rsp_ready = 0;
        c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h10; c_req_size = SZ_W;
        n = 0;
        while (!c_req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        c_req_valid = 0;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h20; d_req_size = SZ_W;
        n = 0;
        do begin @(negedge clk); n++; end while (!c_rsp_valid && n < 20);
        chk("hold_lat", 32'(n), 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, c_rsp_valid}, 1);
            chk("hold_rdata", c_rsp_rdata, 32'h80FF0000);
            chk("hold_no_grant", {30'h0, c_req_ready, d_req_ready}, 0);
        end
        @(posedge clk); #1 c_rsp_ready = 1;
        @(negedge clk);
        chk("hs_cycle_no_grant", {31'h0, d_req_ready}, 0);
        @(negedge clk);
        chk("dead_then_grant", {31'h0, d_req_ready}, 1);
        chk("rsp_dropped", {31'h0, c_rsp_valid}, 0);
        @(posedge clk); #1 d_req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_rsp_valid && n < 20);
        chk("d_after_hold_rdata", d_rsp_rdata, 32'hCAFEF00D);
        @(posedge clk);

        // reset while a load sits in RD_WAIT
        #1;
        c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h10; c_req_size = SZ_W;
        n = 0;
        do begin @(negedge clk); n++; end while (!c_req_ready && n < 20);
        @(posedge clk); #1;
        c_req_valid = 1; d_req_valid = 1; rst_n = 0;
        #1;
        chk("rst_rdwait_ready", {30'h0, c_req_ready, d_req_ready}, 0);
        chk("rst_rdwait_rsp", {28'h0, c_rsp_valid, d_rsp_valid, c_rsp_err, d_rsp_err}, 0);
        chk("rst_rdwait_mem", {27'h0, mem_en, mem_wmask}, 0);
        @(posedge clk); #1;
        c_req_valid = 0; d_req_valid = 0;
        expq.delete();
        rst_n = 1;
        do_req(0, 0, 32'h10, SZ_W, 0, 2, "lw_after_rst", rd, er);
        chk("lw_after_rst_rdata", rd, 32'h80FF0000);

        // both ports hammering: D forced through once every STARVE_MAX+1 grants
        @(posedge clk); #1;
        c_req_valid = 1; c_req_we = 1; c_req_addr = 32'h40; c_req_size = SZ_W; c_req_wdata = 32'h11111111;
        d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h44; d_req_size = SZ_W; d_req_wdata = 32'h22222222;
        g = 0; n = 0;
        while (g < 10 && n < 200) begin
            @(negedge clk); n++;
            if (c_req_ready) begin seq[g] = 0; g++; end
            else if (d_req_ready) begin seq[g] = 1; g++; end
        end
        @(posedge clk); #1;
        c_req_valid = 0; d_req_valid = 0;
        chk("arb_grant_count", 32'(g), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("arb_grant%0d", i), {31'h0, seq[i]}, {31'h0, (i % 5) == 4});

        n = 0;
        while (expq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("drain", 32'(expq.size()), 0);
        chk("ram_c_arb", ram[16], 32'h11111111);
        chk("ram_d_arb", ram[17], 32'h22222222);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
